// File: rtl/wb_burst_bridge_pkg.sv
// Shared configuration for the Wishbone burst-to-single-beat bridge:
// bus widths, burst lengths and FSM state encodings.
package wb_burst_bridge_pkg;

    localparam int unsigned WB_ADDR_W   = 24;
    localparam int unsigned WB_DATA_W   = 16;
    localparam int unsigned WB_SEL_BITS = 2;

    localparam int unsigned BEAT_CNT_W = 4;

    localparam logic [BEAT_CNT_W-1:0] BURST_1 = 4'd1;
    localparam logic [BEAT_CNT_W-1:0] BURST_4 = 4'd4;
    localparam logic [BEAT_CNT_W-1:0] BURST_8 = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT  = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } bridge_state_e;

    // Beat count for a request; the 8-beat hint dominates when both are set.
    function automatic logic [BEAT_CNT_W-1:0] burst_len(input logic b4, input logic b8);
        if (b8) begin
            return BURST_8;
        end else if (b4) begin
            return BURST_4;
        end
        return BURST_1;
    endfunction

endpackage

// File: rtl/wb_bridge_beat_ctr.sv
// Beat counter and address generator for wb_burst_bridge: loads the beat
// count and start address on accept, steps once per acknowledged beat.
module wb_bridge_beat_ctr
    import wb_burst_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = WB_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [BEAT_CNT_W-1:0] len_i,
    input  logic [ADDR_W-1:0]     adr_i,
    input  logic                  step_i,
    output logic [ADDR_W-1:0]     adr_o,
    output logic                  last_o
);

    logic [BEAT_CNT_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0]     adr_q, adr_d;

    // Next count/address; the address only advances while more beats follow
    // and wraps naturally modulo 2^ADDR_W.
    always_comb begin
        rem_d = rem_q;
        adr_d = adr_q;
        if (load_i) begin
            rem_d = len_i;
            adr_d = adr_i;
        end else if (step_i) begin
            rem_d = rem_q - BEAT_CNT_W'(1);
            if (!last_o) begin
                adr_d = adr_q + ADDR_W'(1);
            end
        end
    end

    // Counter and address registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q <= '0;
            adr_q <= '0;
        end else begin
            rem_q <= rem_d;
            adr_q <= adr_d;
        end
    end

    assign adr_o  = adr_q;
    assign last_o = (rem_q == BEAT_CNT_W'(1));

endmodule

// File: rtl/wb_burst_bridge.sv
// Wishbone burst bridge: expands 4/8-beat burst reads into sequential
// classic single-beat transfers, one upstream ack per beat; singles pass
// through with registered timing. All outputs are registered.
// Optional per-beat watchdog: define BRIDGE_TIMEOUT_EN.
module wb_burst_bridge
    import wb_burst_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = WB_ADDR_W,
    parameter int unsigned DATA_W  = WB_DATA_W,
    parameter int unsigned SEL_W   = WB_SEL_BITS,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              u_wb_cyc,
    input  logic              u_wb_stb,
    input  logic              u_wb_we,
    input  logic [ADDR_W-1:0] u_wb_adr,
    input  logic [DATA_W-1:0] u_wb_o_dat,
    input  logic [SEL_W-1:0]  u_wb_sel,
    input  logic              u_wb_4_burst,
    input  logic              u_wb_8_burst,
    output logic [DATA_W-1:0] u_wb_i_dat,
    output logic              u_wb_ack,
    output logic              u_wb_err,
    output logic              d_wb_cyc,
    output logic              d_wb_stb,
    output logic              d_wb_we,
    output logic [ADDR_W-1:0] d_wb_adr,
    output logic [DATA_W-1:0] d_wb_o_dat,
    output logic [SEL_W-1:0]  d_wb_sel,
    input  logic [DATA_W-1:0] d_wb_i_dat,
    input  logic              d_wb_ack,
    input  logic              d_wb_err
);

    bridge_state_e state_q, state_d;

    logic              u_ack_q, u_ack_d;
    logic              u_err_q, u_err_d;
    logic [DATA_W-1:0] u_dat_q, u_dat_d;
    logic              d_cyc_q, d_cyc_d;
    logic              d_stb_q, d_stb_d;
    logic              d_we_q,  d_we_d;
    logic [DATA_W-1:0] d_dat_q, d_dat_d;
    logic [SEL_W-1:0]  d_sel_q, d_sel_d;

    logic              ctr_load, ctr_step, ctr_last;
    logic [ADDR_W-1:0] ctr_adr;

    logic accept, is_burst, illegal, dn_done, tmo_hit;

    // A request seen in the same cycle as our own ack/err is the one just finished.
    assign accept   = u_wb_cyc & u_wb_stb & ~u_ack_q & ~u_err_q;
    assign is_burst = u_wb_4_burst | u_wb_8_burst;
    assign illegal  = is_burst & u_wb_we;
    assign dn_done  = d_wb_ack | d_wb_err;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Per-beat watchdog: counts BEAT/DRAIN cycles, restarts on every beat issue.
    always_comb begin
        tmo_d = '0;
        if (state_q == ST_BEAT || state_q == ST_DRAIN) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = (state_q == ST_BEAT || state_q == ST_DRAIN) &&
                     (tmo_q == TMO_W'(TIMEOUT - 1));
`else
    // Without the watchdog a beat waits for the slave indefinitely.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
`endif

    wb_bridge_beat_ctr #(
        .ADDR_W (ADDR_W)
    ) u_beat_ctr (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .load_i (ctr_load),
        .len_i  (burst_len(u_wb_4_burst, u_wb_8_burst)),
        .adr_i  (u_wb_adr),
        .step_i (ctr_step),
        .adr_o  (ctr_adr),
        .last_o (ctr_last)
    );

    // State and registered-output update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            u_ack_q <= 1'b0;
            u_err_q <= 1'b0;
            u_dat_q <= '0;
            d_cyc_q <= 1'b0;
            d_stb_q <= 1'b0;
            d_we_q  <= 1'b0;
            d_dat_q <= '0;
            d_sel_q <= '0;
        end else begin
            state_q <= state_d;
            u_ack_q <= u_ack_d;
            u_err_q <= u_err_d;
            u_dat_q <= u_dat_d;
            d_cyc_q <= d_cyc_d;
            d_stb_q <= d_stb_d;
            d_we_q  <= d_we_d;
            d_dat_q <= d_dat_d;
            d_sel_q <= d_sel_d;
        end
    end

    // Next-state logic; an upstream abort outranks downstream responses.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !illegal) state_d = ST_BEAT;
            end
            ST_BEAT: begin
                if (!u_wb_cyc)     state_d = (dn_done || tmo_hit) ? ST_IDLE : ST_DRAIN;
                else if (d_wb_err) state_d = ST_IDLE;
                else if (d_wb_ack) state_d = ctr_last ? ST_IDLE : ST_GAP;
                else if (tmo_hit)  state_d = ST_IDLE;
            end
            ST_GAP: begin
                state_d = u_wb_cyc ? ST_BEAT : ST_IDLE;
            end
            ST_DRAIN: begin
                if (dn_done || tmo_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and beat-counter controls.
    always_comb begin
        u_ack_d  = 1'b0;
        u_err_d  = 1'b0;
        u_dat_d  = u_dat_q;
        d_cyc_d  = d_cyc_q;
        d_stb_d  = d_stb_q;
        d_we_d   = d_we_q;
        d_dat_d  = d_dat_q;
        d_sel_d  = d_sel_q;
        ctr_load = 1'b0;
        ctr_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        u_err_d = 1'b1;
                    end else begin
                        d_cyc_d  = 1'b1;
                        d_stb_d  = 1'b1;
                        d_we_d   = u_wb_we;
                        d_dat_d  = u_wb_o_dat;
                        d_sel_d  = u_wb_sel;
                        ctr_load = 1'b1;
                    end
                end
            end
            ST_BEAT: begin
                if (!u_wb_cyc) begin
                    if (dn_done || tmo_hit) begin
                        d_cyc_d = 1'b0;
                        d_stb_d = 1'b0;
                    end
                end else if (d_wb_err || tmo_hit) begin
                    u_err_d = 1'b1;
                    d_cyc_d = 1'b0;
                    d_stb_d = 1'b0;
                end else if (d_wb_ack) begin
                    u_ack_d  = 1'b1;
                    u_dat_d  = d_wb_i_dat;
                    ctr_step = 1'b1;
                    d_stb_d  = 1'b0;
                    if (ctr_last) d_cyc_d = 1'b0;
                end
            end
            ST_GAP: begin
                if (u_wb_cyc) d_stb_d = 1'b1;
                else          d_cyc_d = 1'b0;
            end
            ST_DRAIN: begin
                if (dn_done || tmo_hit) begin
                    d_cyc_d = 1'b0;
                    d_stb_d = 1'b0;
                end
            end
            default: begin
                d_cyc_d = 1'b0;
                d_stb_d = 1'b0;
            end
        endcase
    end

    assign u_wb_ack   = u_ack_q;
    assign u_wb_err   = u_err_q;
    assign u_wb_i_dat = u_dat_q;
    assign d_wb_cyc   = d_cyc_q;
    assign d_wb_stb   = d_stb_q;
    assign d_wb_we    = d_we_q;
    assign d_wb_adr   = ctr_adr;
    assign d_wb_o_dat = d_dat_q;
    assign d_wb_sel   = d_sel_q;

endmodule
